// File: rtl/gps_uart_tx.sv
// gps_uart_tx: 8N1 UART transmitter with two selectable line speeds.
// Latency: tx falls at the edge that accepts send; a frame lasts 10 bit times
//   (10*CLKS clocks), and busy falls at the same edge that IDLE is re-entered.
// Backpressure: send is ignored while busy=1 or while a speed change is being
//   applied. There is no queueing, so the requester retries once busy=0.
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous active-low reset
//   data      - byte to send, sampled only at the accepting edge
//   send      - transmit request, sampled every clock
//   busy      - high while a frame is in progress
//   req_speed - requested line speed (0 = slow, 1 = fast), applied only in IDLE
//   cur_speed - line speed currently in force
//   tx        - serial line (idle high), driven from a register
module gps_uart_tx #(
  parameter int CLKS_SLOW = 5208,
  parameter int CLKS_FAST = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       send,
  output logic       busy,
  input  logic       req_speed,
  output logic       cur_speed,
  output logic       tx
);

  // The counter only has to reach CLKS-1 for the slower of the two speeds.
  localparam int CMAX = (CLKS_SLOW > CLKS_FAST) ? CLKS_SLOW : CLKS_FAST;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          spd_q, spd_d;

  logic [CW-1:0] bit_last;
  logic          bit_end;

  assign bit_last = spd_q ? CW'(CLKS_FAST - 1) : CW'(CLKS_SLOW - 1);
  assign bit_end  = (cnt_q == bit_last);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    spd_d   = spd_q;

    // The counter restarts at each bit boundary, so every bit is exactly CLKS clocks.
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A pending speed change takes priority and swallows a same-cycle send,
        // so a frame never starts with a speed other than the requested one.
        if (req_speed != spd_q) begin
          spd_d = req_speed;
        end else if (send) begin
          byte_d  = data;
          idx_d   = 3'd0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = 3'd0;
          tx_d    = byte_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = byte_q[idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      byte_q  <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      spd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      spd_q   <= spd_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign cur_speed = spd_q;

endmodule

// File: tb/tb_gps_uart_tx.sv
// tb_gps_uart_tx: directed bench for gps_uart_tx with a bit-level scoreboard.
// Latency: expected frames are checked every clock from the accepting edge
//   through the edge at which busy falls.
// Backpressure: exercises ignored sends while busy and during speed changes.
module tb_gps_uart_tx;

  localparam int SLOW = 16;
  localparam int FAST = 4;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       send;
  logic       busy;
  logic       req_speed;
  logic       cur_speed;
  logic       tx;

  int compared = 0;
  int mismatched = 0;

  logic exp_q[$];

  gps_uart_tx #(.CLKS_SLOW(SLOW), .CLKS_FAST(FAST)) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .send(send),
    .busy(busy),
    .req_speed(req_speed),
    .cur_speed(cur_speed),
    .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard producer: the expected line sequence for one 8N1 frame.
  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(1'b1);
  endtask

  // Called at the negedge right after the accepting edge. Checks every clock of
  // the frame against the scoreboard, then checks the post-frame idle state.
  // act_cyc >= 0 injects a mid-frame send + speed toggle; abort_cyc >= 0 resets.
  task automatic check_frame(input int clks, input logic spd, input string tag,
                             input int act_cyc, input logic [7:0] act_dat,
                             input int abort_cyc);
    logic eb;
    eb = 1'b1;
    for (int n = 0; n < 10 * clks; n++) begin
      if (n % clks == 0) begin
        chk({tag, " sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) eb = exp_q.pop_front();
      end
      chk({tag, " tx"}, 32'(tx), 32'(eb));
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " cur_speed"}, 32'(cur_speed), 32'(spd));
      if (n == abort_cyc) begin
        rst = 1'b0;
        #1;
        chk({tag, " abort_tx"}, 32'(tx), 32'd1);
        chk({tag, " abort_busy"}, 32'(busy), 32'd0);
        chk({tag, " abort_speed"}, 32'(cur_speed), 32'd0);
        exp_q.delete();
        return;
      end
      if (act_cyc >= 0 && n == act_cyc) begin
        send = 1'b1;
        data = act_dat;
        req_speed = ~req_speed;
      end
      if (act_cyc >= 0 && n == act_cyc + 1) begin
        send = 1'b0;
        data = 8'h00;
      end
      @(negedge clk);
    end
    chk({tag, " end_busy"}, 32'(busy), 32'd0);
    chk({tag, " end_tx"}, 32'(tx), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    data = 8'h00;
    send = 1'b0;
    req_speed = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset cur_speed", 32'(cur_speed), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset busy", 32'(busy), 32'd0);

    // Slow frame of A5 from a single-cycle send pulse.
    data = 8'hA5;
    send = 1'b1;
    push_frame(8'hA5);
    @(negedge clk);
    send = 1'b0;
    data = 8'h00;
    check_frame(SLOW, 1'b0, "a5_slow", -1, 8'h00, -1);

    // Speed change in IDLE swallows the same-cycle send.
    req_speed = 1'b1;
    send = 1'b1;
    data = 8'h99;
    @(negedge clk);
    chk("spdchg cur_speed", 32'(cur_speed), 32'd1);
    chk("spdchg busy", 32'(busy), 32'd0);
    chk("spdchg tx", 32'(tx), 32'd1);
    data = 8'h3C;
    push_frame(8'h3C);
    @(negedge clk);
    send = 1'b0;
    check_frame(FAST, 1'b1, "3c_fast", -1, 8'h00, -1);

    // Back to slow, then a frame with a mid-frame send of FF and a speed toggle.
    req_speed = 1'b0;
    @(negedge clk);
    chk("to_slow cur_speed", 32'(cur_speed), 32'd0);
    data = 8'h5A;
    send = 1'b1;
    push_frame(8'h5A);
    @(negedge clk);
    send = 1'b0;
    check_frame(SLOW, 1'b0, "busy_ignore", 20, 8'hFF, -1);
    chk("busy_ignore speed_held", 32'(cur_speed), 32'd0);
    @(negedge clk);
    chk("busy_ignore speed_applied", 32'(cur_speed), 32'd1);
    chk("busy_ignore no_second", 32'(busy), 32'd0);
    @(negedge clk);
    chk("busy_ignore still_idle", 32'(busy), 32'd0);
    chk("busy_ignore idle_tx", 32'(tx), 32'd1);

    // Send held high: three back-to-back fast frames, one idle clock apart.
    data = 8'h00;
    send = 1'b1;
    for (int f = 0; f < 3; f++) push_frame(8'h00);
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      check_frame(FAST, 1'b1, $sformatf("held%0d", f), -1, 8'h00, -1);
      if (f == 2) send = 1'b0;
      @(negedge clk);
    end
    chk("held stop busy", 32'(busy), 32'd0);
    chk("held stop sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset at clock 70 of a slow frame, then a clean 55 frame.
    req_speed = 1'b0;
    @(negedge clk);
    chk("pre_abort cur_speed", 32'(cur_speed), 32'd0);
    data = 8'hC3;
    send = 1'b1;
    push_frame(8'hC3);
    @(negedge clk);
    send = 1'b0;
    check_frame(SLOW, 1'b0, "abort", -1, 8'h00, 70);
    @(negedge clk);
    chk("abort held tx", 32'(tx), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("release busy", 32'(busy), 32'd0);
    chk("release tx", 32'(tx), 32'd1);
    chk("release cur_speed", 32'(cur_speed), 32'd0);
    data = 8'h55;
    send = 1'b1;
    push_frame(8'h55);
    @(negedge clk);
    send = 1'b0;
    check_frame(SLOW, 1'b0, "55_after_rst", -1, 8'h00, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gps_uart_tx.md
GPS_UART_TX -- requirements
Module: gps_uart_tx

Interface
REQ-001 Parameter CLKS_SLOW, default 5208, shall set clocks per bit at slow speed (9600 baud at 50 MHz).
REQ-002 Parameter CLKS_FAST, default 434, shall set clocks per bit at fast speed (115200 baud at 50 MHz).
REQ-003 clk  input  1  shall be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  shall be the reset, asynchronous and active-low (0 = reset asserted).
REQ-005 data  input  8  shall be the byte to transmit, sampled only when a send is accepted.
REQ-006 send  input  1  shall be the transmit request, sampled each clock.
REQ-007 busy  output  1  shall be high while a frame is in progress.
REQ-008 req_speed  input  1  shall request the line speed: 0 = slow, 1 = fast.
REQ-009 cur_speed  output  1  shall report the speed currently in force.
REQ-010 tx  output  1  shall be the serial line, idle high, driven from a register.

Function
REQ-011 Frame format shall be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-012 States shall be IDLE, START, DATA and STOP.
REQ-013 Every bit shall last exactly CLKS(cur_speed) clocks. CLKS(0) = CLKS_SLOW and CLKS(1) = CLKS_FAST.
REQ-014 The bit counter shall be wide enough for the larger of CLKS_SLOW-1 and CLKS_FAST-1, and shall reload to 0 at each bit boundary.
REQ-015 IDLE with req_speed != cur_speed: cur_speed shall take req_speed at that edge; any send in the same cycle shall be ignored and busy shall stay 0.
REQ-016 IDLE with req_speed == cur_speed and send=1: the byte shall be latched, and at that same edge state -> START, tx -> 0, busy -> 1.
REQ-017 START shall hold tx=0 for one bit time, then go to DATA with tx = bit 0.
REQ-018 DATA shall shift out bits 0..7 with a 3-bit index; after bit 7 it shall go to STOP with tx=1.
REQ-019 STOP shall hold tx=1 for one bit time. At the end of the stop bit, state -> IDLE and busy -> 0 at the same edge.
REQ-020 Total frame time shall be 10*CLKS clocks from the accepting edge to busy falling.
REQ-021 send while busy=1 shall be ignored; there is no queueing and data changes shall have no effect on the frame in progress.
REQ-022 req_speed changes while busy=1 shall not alter cur_speed or bit timing until IDLE is re-entered.
REQ-023 A send held high continuously shall start a new frame on the first IDLE cycle with matching speed. The minimum gap is one IDLE clock, with tx=1.
REQ-024 busy shall fall in the same cycle that IDLE is entered, so a one-cycle send pulse issued on seeing busy=0 is accepted.

Reset
REQ-025 On rst=0, asynchronously: state=IDLE, tx=1, busy=0, cur_speed=0, bit counter=0, bit index=0, latched byte=0.
REQ-026 Reset asserted mid-frame shall abort the frame immediately, with tx high before the next clock edge.
REQ-027 After rst returns to 1, the first edge shall behave as IDLE.

Verification (bench overrides CLKS_SLOW=16, CLKS_FAST=4)
REQ-028 Reset then send=1 for one cycle with data=8'hA5, speeds matched at 0 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks; busy high for 160 clocks.
REQ-029 req_speed=1 while idle with send=1 in the same cycle -> cur_speed=1 after one edge and busy stays 0. send=1 the next cycle with data=8'h3C -> frame of 40 clocks, bits 0,0,0,1,1,1,1,0,0,1.
REQ-030 send pulsed at clock 20 of a frame with data=8'hFF, and req_speed toggled mid-frame -> the frame is unchanged, no second frame starts, and cur_speed changes only after busy falls.
REQ-031 send held high with data=8'h00 for 3 frames at fast speed -> three 40-clock frames, each separated by exactly one idle clock with tx=1.
REQ-032 rst driven low at clock 70 of a slow frame -> tx=1 and busy=0 immediately, cur_speed=0. After release, a send of 8'h55 produces a clean full frame.
